// File: rtl/ex_stage_unit.sv
// ex_stage_unit -- execute stage of the 16-bit pipeline.
//
// Consumes the ID/EX bundle, computes single-cycle ALU results and runs an
// iterative shift-add multiplier.  While the multiplier is busy, stall_out
// holds the ID/EX register.  All outputs are registered and form the EX/WB
// bundle.
//
// Optional feature: define EX_MULT_EN to build the multiplier.  Without it,
// opcode 1000 (MUL) is treated as illegal and stall_out is constant 0.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   in_valid       ID/EX bundle holds a valid instruction
//   opcode_in      4-bit opcode
//   op_a, op_b     register-file operands
//   imm            sign-extended immediate (LI)
//   rd_in          destination register index
//   stall_out      ID/EX must hold its contents (registered)
//   res_valid      one-cycle pulse per completed instruction
//   res_data       result
//   res_rd         destination index
//   res_opcode     propagated opcode
//   res_wr_en      writeback enable
//   res_zero       res_data == 0, valid with res_valid
//   illegal        sticky unknown-opcode flag, cleared only by reset

module ex_stage_unit #(
  parameter int DATA_W     = 16,
  parameter int RD_W       = 3,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        opcode_in,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [RD_W-1:0]   rd_in,
  output logic              stall_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [RD_W-1:0]   res_rd,
  output logic [3:0]        res_opcode,
  output logic              res_wr_en,
  output logic              res_zero,
  output logic              illegal
);

  if (MUL_CYCLES != DATA_W) begin : g_bad_cfg
    $error("ex_stage_unit: MUL_CYCLES must equal DATA_W");
  end

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_LI  = 4'b1001;

  typedef enum logic {
    S_IDLE,
    S_MUL_RUN
  } state_t;

  state_t state_q, state_d;

  logic              stall_d;
  logic              res_valid_d;
  logic [DATA_W-1:0] res_data_d;
  logic [RD_W-1:0]   res_rd_d;
  logic [3:0]        res_opcode_d;
  logic              res_wr_en_d;
  logic              res_zero_d;
  logic              illegal_d;

  // Single-cycle ALU
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr;
  logic              alu_ill;

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    alu_ill = 1'b0;
    unique case (opcode_in)
      OP_NOP: alu_wr = 1'b0;
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL: alu_res = op_a << op_b[3:0];
      OP_SRL: alu_res = op_a >> op_b[3:0];
      OP_LI:  alu_res = imm;
      default: begin
        // Covers 1010-1111, and MUL when the multiplier is not built.
        alu_wr  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
  end

`ifdef EX_MULT_EN
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [DATA_W-1:0] b_sh_q, b_sh_d;
  logic [RD_W-1:0]   rd_sh_q, rd_sh_d;
  logic [DATA_W-1:0] acc_step;

  // Accumulator value after the current iteration; on the last iteration
  // this goes straight to res_data so no extra drain cycle is needed.
  assign acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);
`endif

  always_comb begin
    state_d      = state_q;
    stall_d      = stall_out;
    res_valid_d  = 1'b0;
    res_data_d   = res_data;
    res_rd_d     = res_rd;
    res_opcode_d = res_opcode;
    res_wr_en_d  = 1'b0;
    res_zero_d   = res_zero;
    illegal_d    = illegal;
`ifdef EX_MULT_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    rd_sh_d = rd_sh_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef EX_MULT_EN
          if (opcode_in == OP_MUL) begin
            a_sh_d  = op_a;
            b_sh_d  = op_b;
            rd_sh_d = rd_in;
            acc_d   = '0;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            stall_d = 1'b1;
            state_d = S_MUL_RUN;
          end else
`endif
          begin
            res_valid_d  = 1'b1;
            res_data_d   = alu_res;
            res_zero_d   = (alu_res == '0);
            res_rd_d     = rd_in;
            res_opcode_d = opcode_in;
            res_wr_en_d  = alu_wr;
            illegal_d    = illegal | alu_ill;
          end
        end
      end
      S_MUL_RUN: begin
`ifdef EX_MULT_EN
        acc_d  = acc_step;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          res_valid_d  = 1'b1;
          res_data_d   = acc_step;
          res_zero_d   = (acc_step == '0);
          res_rd_d     = rd_sh_q;
          res_opcode_d = OP_MUL;
          res_wr_en_d  = 1'b1;
          stall_d      = 1'b0;
          state_d      = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stall_out  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
      res_opcode <= '0;
      res_wr_en  <= 1'b0;
      res_zero   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_out  <= stall_d;
      res_valid  <= res_valid_d;
      res_data   <= res_data_d;
      res_rd     <= res_rd_d;
      res_opcode <= res_opcode_d;
      res_wr_en  <= res_wr_en_d;
      res_zero   <= res_zero_d;
      illegal    <= illegal_d;
    end
  end

`ifdef EX_MULT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      rd_sh_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      rd_sh_q <= rd_sh_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage_unit.sv
module tb_ex_stage_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  opcode_in;
  logic [15:0] op_a, op_b, imm;
  logic [2:0]  rd_in;
  logic        stall_out, res_valid, res_wr_en, res_zero, illegal;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic [3:0]  res_opcode;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic [3:0]  op;
    logic        wr;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic [15:0] exp_data;
    logic        exp_wr;
  } vec_t;

  exp_t exp_q[$];
  logic stall_seen = 1'b0;

  ex_stage_unit #(.DATA_W(16), .RD_W(3), .MUL_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode_in(opcode_in),
    .op_a(op_a), .op_b(op_b), .imm(imm), .rd_in(rd_in),
    .stall_out(stall_out), .res_valid(res_valid), .res_data(res_data),
    .res_rd(res_rd), .res_opcode(res_opcode), .res_wr_en(res_wr_en),
    .res_zero(res_zero), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Monitor: every res_valid pulse pops one expected bundle.
  always @(negedge clock) begin
    exp_t e;
    if (stall_out) stall_seen = 1'b1;
    if (!reset && res_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_res_valid: data=%h rd=%0d op=%b", res_data, res_rd, res_opcode);
      end else begin
        e = exp_q.pop_front();
        if ({res_data, res_rd, res_opcode, res_wr_en, res_zero} !== e) begin
          fails++;
          $display("FAIL result op=%b: got data=%h rd=%0d op=%b wr=%b zero=%b, want data=%h rd=%0d op=%b wr=%b zero=%b",
                   e.op, res_data, res_rd, res_opcode, res_wr_en, res_zero,
                   e.data, e.rd, e.op, e.wr, e.zero);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] im, input logic [2:0] rd);
    in_valid  = 1'b1;
    opcode_in = op;
    op_a      = a;
    op_b      = b;
    imm       = im;
    rd_in     = rd;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    drive(v.op, v.a, v.b, v.imm, v.rd);
    e.data = v.exp_data;
    e.rd   = v.rd;
    e.op   = v.op;
    e.wr   = v.exp_wr;
    e.zero = (v.exp_data == 16'h0);
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  vec_t alu_vecs[9];

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; opcode_in = '0;
    op_a = '0; op_b = '0; imm = '0; rd_in = '0;

    // Hand-computed ALU vectors: op, a, b, imm, rd, expected data, expected wr_en
    alu_vecs[0] = '{4'b0001, 16'h7FFF, 16'h0001, 16'h0000, 3'd1, 16'h8000, 1'b1}; // ADD
    alu_vecs[1] = '{4'b0010, 16'h0005, 16'h0005, 16'h0000, 3'd2, 16'h0000, 1'b1}; // SUB -> zero
    alu_vecs[2] = '{4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 3'd3, 16'h0001, 1'b1}; // SLT signed
    alu_vecs[3] = '{4'b0111, 16'h8000, 16'h000F, 16'h0000, 3'd4, 16'h0001, 1'b1}; // SRL
    alu_vecs[4] = '{4'b0110, 16'h0001, 16'h0013, 16'h0000, 3'd5, 16'h0008, 1'b1}; // SLL uses b[3:0]
    alu_vecs[5] = '{4'b0011, 16'hF0F0, 16'h0FF0, 16'h0000, 3'd6, 16'h00F0, 1'b1}; // AND
    alu_vecs[6] = '{4'b0100, 16'hF000, 16'h000F, 16'h0000, 3'd7, 16'hF00F, 1'b1}; // OR
    alu_vecs[7] = '{4'b0000, 16'h1111, 16'h2222, 16'h0000, 3'd0, 16'h0000, 1'b0}; // NOP
    alu_vecs[8] = '{4'b1001, 16'hAAAA, 16'h5555, 16'h1234, 3'd2, 16'h1234, 1'b1}; // LI

    do_reset(2);
    check("reset_res_valid", {31'b0, res_valid}, 32'd0);
    check("reset_res_data", {16'b0, res_data}, 32'd0);
    check("reset_res_rd", {29'b0, res_rd}, 32'd0);
    check("reset_res_opcode", {28'b0, res_opcode}, 32'd0);
    check("reset_wr_en", {31'b0, res_wr_en}, 32'd0);
    check("reset_zero", {31'b0, res_zero}, 32'd0);
    check("reset_stall", {31'b0, stall_out}, 32'd0);
    check("reset_illegal", {31'b0, illegal}, 32'd0);

    foreach (alu_vecs[i]) issue(alu_vecs[i]);

    // Idle cycle: no valid, no write, data held from the LI
    tick();
    check("idle_res_valid", {31'b0, res_valid}, 32'd0);
    check("idle_wr_en", {31'b0, res_wr_en}, 32'd0);
    check("idle_data_hold", {16'b0, res_data}, 32'h1234);
    check("no_illegal_yet", {31'b0, illegal}, 32'd0);

`ifdef EX_MULT_EN
    // MUL with in_valid held for the whole stall
    begin
      exp_t e;
      drive(4'b1000, 16'h0123, 16'h0045, 16'h0000, 3'd5);
      e = '{16'h4E6F, 3'd5, 4'b1000, 1'b1, 1'b0};
      exp_q.push_back(e);
      tick();
      cnt = 0;
      while (stall_out && cnt < 40) begin
        cnt++;
        tick();
      end
      check("mul_stall_cycles", cnt, 32'd16);
      check("mul_valid_at_stall_drop", {31'b0, res_valid}, 32'd1);
      // Upstream advances: following ADD accepted on the next edge
      issue('{4'b0001, 16'h0010, 16'h0020, 16'h0000, 3'd6, 16'h0030, 1'b1});
      tick();
      check("mul_no_illegal", {31'b0, illegal}, 32'd0);
    end

    // MUL aborted by reset in its 8th MUL_RUN cycle: no result may appear
    drive(4'b1000, 16'h0003, 16'h0004, 16'h0000, 3'd1);
    tick();
    check("abort_stall_on", {31'b0, stall_out}, 32'd1);
    repeat (7) tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("abort_stall", {31'b0, stall_out}, 32'd0);
    check("abort_valid", {31'b0, res_valid}, 32'd0);
    check("abort_data", {16'b0, res_data}, 32'd0);
    check("abort_rd", {29'b0, res_rd}, 32'd0);
    reset = 1'b0;
    repeat (25) tick();
    check("abort_stall_idle", {31'b0, stall_out}, 32'd0);
`endif

    // Illegal opcode, then NOP: sticky flag, no writes
    do_reset(2);
    stall_seen = 1'b0;
    issue('{4'b1100, 16'h1234, 16'h5678, 16'h0000, 3'd3, 16'h0000, 1'b0});
    check("illegal_set", {31'b0, illegal}, 32'd1);
    issue('{4'b0000, 16'h0000, 16'h0000, 16'h0000, 3'd4, 16'h0000, 1'b0});
    check("illegal_sticky", {31'b0, illegal}, 32'd1);
    tick();
    check("illegal_sticky_idle", {31'b0, illegal}, 32'd1);

`ifndef EX_MULT_EN
    // Without the multiplier, MUL is illegal and never stalls
    do_reset(2);
    stall_seen = 1'b0;
    issue('{4'b1000, 16'h0123, 16'h0045, 16'h0000, 3'd5, 16'h0000, 1'b0});
    check("nomul_illegal", {31'b0, illegal}, 32'd1);
    repeat (20) tick();
    check("nomul_stall_never", {31'b0, stall_seen}, 32'd0);
`endif

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
